qspi_slave_ctrl: RTL and testbench

// Transaction sequencer for the 2-bit host link (qd[1:0], dcs, dsck) behind the SB_IO tristate pair.

---
 rtl/qspi_slave_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_qspi_slave_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_slave_ctrl.sv
// qspi_slave_ctrl: command/data sequencer for the 2-bit host link onto an 8-bit register bus.
// Latency: pins pass SYNC_STAGES flops + edge detect; bus_wr 1 clk after 4th rising-edge detect.
// Backpressure: none; host dsck high/low >= 4 clk and a fixed 1-clk bus_rdata latency are assumed.
// Build option: define QSPI_CTRL_DBG_EN to add dbg_byte, dbg_state and frame_cnt ports.
module qspi_slave_ctrl #(
  parameter int ADDR_W       = 7,
  parameter int DUMMY_CYCLES = 2,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_ss,
  input  logic              io_sclk,
  input  logic [1:0]        io_qd_read,
  output logic [1:0]        io_qd_write,
  output logic [1:0]        io_qd_writeEnable,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  output logic              bus_wr,
  output logic              bus_rd,
  input  logic [7:0]        bus_rdata,
  output logic              busy
`ifdef QSPI_CTRL_DBG_EN
  ,
  output logic [7:0]        dbg_byte,
  output logic [2:0]        dbg_state,
  output logic [15:0]       frame_cnt
`endif
);

  localparam int DW = $clog2(DUMMY_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    WDATA = 3'd2,
    TURN  = 3'd3,
    RDATA = 3'd4
  } state_t;

  state_t                       state, state_nxt;
  logic [SYNC_STAGES-1:0]       ss_sync, sclk_sync;
  logic [SYNC_STAGES-1:0][1:0]  qd_sync;
  logic                         ss_s, sclk_s, sclk_q, rise, fall;
  logic [1:0]                   qd_s;
  logic [5:0]                   sh_in;
  logic [1:0]                   in_cnt;
  logic [7:0]                   in_byte;
  logic                         byte_done;
  logic [7:0]                   sh_out, pf;
  logic [1:0]                   out_cnt;
  logic [DW-1:0]                dummy_cnt;
  logic                         dummy_done;
  logic [1:0]                   rd_issued;
  logic                         rd_dly, fill_sh;

  // Pin synchronisers; ss resets high so reset release never fakes a frame start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ss_sync   <= '1;
      sclk_sync <= '0;
      qd_sync   <= '0;
      sclk_q    <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], io_ss};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], io_sclk};
      qd_sync   <= {qd_sync[SYNC_STAGES-2:0], io_qd_read};
      sclk_q    <= sclk_s;
    end
  end

  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign qd_s   = qd_sync[SYNC_STAGES-1];
  // A deasserted select masks any coincident clock edge.
  assign rise   = sclk_s & ~sclk_q & ~ss_s;
  assign fall   = ~sclk_s & sclk_q & ~ss_s;

  assign in_byte    = {sh_in, qd_s};
  assign byte_done  = rise && (in_cnt == 2'd3);
  assign dummy_done = (dummy_cnt == DW'(DUMMY_CYCLES));

  assign io_qd_writeEnable = {2{state == RDATA}};
  assign busy              = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: select release aborts from any state in the same clk.
  always_comb begin
    state_nxt = state;
    if (ss_s) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = CMD;
        CMD:     if (byte_done) state_nxt = in_byte[7] ? TURN : WDATA;
        TURN:    if (fall && dummy_done) state_nxt = RDATA;
        default: state_nxt = state;
      endcase
    end
  end

  // Shifters, bus strobes, address counter and pad data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_in       <= '0;
      in_cnt      <= '0;
      sh_out      <= '0;
      pf          <= '0;
      out_cnt     <= '0;
      dummy_cnt   <= '0;
      rd_issued   <= '0;
      rd_dly      <= 1'b0;
      fill_sh     <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      bus_wr      <= 1'b0;
      bus_rd      <= 1'b0;
      io_qd_write <= '0;
    end else begin
      bus_wr <= 1'b0;
      bus_rd <= 1'b0;
      rd_dly <= bus_rd;
      if (bus_wr || bus_rd) bus_addr <= bus_addr + 1'b1;
      // Read data lands one clk after its strobe: first goes to the shifter, later ones to prefetch.
      if (rd_dly) begin
        if (fill_sh) begin
          sh_out  <= bus_rdata;
          fill_sh <= 1'b0;
        end else begin
          pf <= bus_rdata;
        end
      end
      case (state)
        IDLE: begin
          in_cnt      <= '0;
          io_qd_write <= '0;
        end
        CMD, WDATA: begin
          if (rise) begin
            sh_in  <= {sh_in[3:0], qd_s};
            in_cnt <= in_cnt + 2'd1;
          end
          if (byte_done && state == CMD) begin
            bus_addr  <= in_byte[ADDR_W-1:0];
            fill_sh   <= in_byte[7];
            rd_issued <= '0;
            dummy_cnt <= '0;
          end
          if (byte_done && state == WDATA) begin
            bus_wr    <= 1'b1;
            bus_wdata <= in_byte;
          end
        end
        TURN: begin
          if (!ss_s && rd_issued == 2'd0) begin
            bus_rd    <= 1'b1;
            rd_issued <= 2'd1;
          end else if (!ss_s && rd_issued == 2'd1 && !bus_rd) begin
            bus_rd    <= 1'b1;
            rd_issued <= 2'd2;
          end
          if (rise && !dummy_done) dummy_cnt <= dummy_cnt + 1'b1;
          if (fall && dummy_done) begin
            io_qd_write <= sh_out[7:6];
            sh_out      <= {sh_out[5:0], 2'b00};
            out_cnt     <= 2'd1;
          end
        end
        RDATA: begin
          if (fall) begin
            if (out_cnt == 2'd0) begin
              io_qd_write <= pf[7:6];
              sh_out      <= {pf[5:0], 2'b00};
              bus_rd      <= 1'b1;
            end else begin
              io_qd_write <= sh_out[7:6];
              sh_out      <= {sh_out[5:0], 2'b00};
            end
            out_cnt <= out_cnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef QSPI_CTRL_DBG_EN
  logic       ss_q;
  logic [7:0] out_byte;

  // Debug view: last finished byte either direction, frame count on select release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ss_q      <= 1'b1;
      out_byte  <= '0;
      dbg_byte  <= '0;
      frame_cnt <= '0;
    end else begin
      ss_q <= ss_s;
      if (ss_s && !ss_q) frame_cnt <= frame_cnt + 16'd1;
      if (rd_dly && fill_sh) out_byte <= bus_rdata;
      else if (state == RDATA && fall && out_cnt == 2'd0) out_byte <= pf;
      if (byte_done && (state == CMD || state == WDATA)) dbg_byte <= in_byte;
      else if (state == RDATA && fall && out_cnt == 2'd3) dbg_byte <= out_byte;
    end
  end

  assign dbg_state = state;
`endif

endmodule

// File: tb/tb_qspi_slave_ctrl.sv
// tb_qspi_slave_ctrl: host-side driver, register bus model and byte-level reference memory.
// Host runs dsck at 5 clk high / 5 clk low; bus_rdata is presented only in the clk after bus_rd.
// Write frames are checked against expected (address, data) lists; read frames against ref_mem.
`timescale 1ns/1ps
module tb_qspi_slave_ctrl;
  localparam int ADDR_W = 7;
  localparam int DUMMY  = 2;
  localparam int SS     = 2;
  localparam int HALF   = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        io_ss = 1'b1;
  logic        io_sclk = 1'b0;
  logic [1:0]  io_qd_read = 2'b00;
  logic [1:0]  io_qd_write, io_qd_writeEnable;
  logic [6:0]  bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata = 8'h00;
  logic        bus_wr, bus_rd, busy;
`ifdef QSPI_CTRL_DBG_EN
  logic [7:0]  dbg_byte;
  logic [2:0]  dbg_state;
  logic [15:0] frame_cnt;
`endif

  int          n_chk = 0;
  int          n_fail = 0;
  int          oe_bad = 0;
  int          both_bad = 0;
  logic        allow_oe = 1'b0;
  logic [7:0]  bus_mem [128];
  logic [7:0]  ref_mem [128];
  logic [7:0]  wdat [8];
  logic [14:0] wlog [$];
  logic        rd_seen = 1'b0;
  logic [6:0]  rd_addr = '0;
  logic [1:0]  mq, moe;

  qspi_slave_ctrl #(.ADDR_W(ADDR_W), .DUMMY_CYCLES(DUMMY), .SYNC_STAGES(SS)) dut (
    .clk               (clk),
    .reset             (reset),
    .io_ss             (io_ss),
    .io_sclk           (io_sclk),
    .io_qd_read        (io_qd_read),
    .io_qd_write       (io_qd_write),
    .io_qd_writeEnable (io_qd_writeEnable),
    .bus_addr          (bus_addr),
    .bus_wdata         (bus_wdata),
    .bus_wr            (bus_wr),
    .bus_rd            (bus_rd),
    .bus_rdata         (bus_rdata),
    .busy              (busy)
`ifdef QSPI_CTRL_DBG_EN
    ,
    .dbg_byte          (dbg_byte),
    .dbg_state         (dbg_state),
    .frame_cnt         (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Bus model and protocol monitors, evaluated mid-cycle.
  always @(negedge clk) begin
    bus_rdata = rd_seen ? bus_mem[rd_addr] : 8'($urandom);
    rd_seen   = bus_rd;
    rd_addr   = bus_addr;
    if (bus_wr) begin
      wlog.push_back({bus_addr, bus_wdata});
      bus_mem[bus_addr] = bus_wdata;
    end
    if (bus_wr && bus_rd) both_bad++;
    if (io_qd_writeEnable != 2'b00 && (!allow_oe || io_qd_writeEnable != 2'b11)) oe_bad++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One dsck period: data set while low, host samples the slave on the rising edge.
  task automatic pair(input logic [1:0] d, output logic [1:0] q, output logic [1:0] oe);
    io_qd_read = d;
    clk_wait(HALF);
    io_sclk = 1'b1;
    q  = io_qd_write;
    oe = io_qd_writeEnable;
    clk_wait(HALF);
    io_sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [1:0] q, oe;
    for (int p = 0; p < 4; p++) pair(b[7-2*p -: 2], q, oe);
  endtask

  task automatic run_write(input logic [7:0] cmd, input int n);
    logic [6:0] a;
    wlog.delete();
    io_ss = 1'b0;
    clk_wait(6);
    send_byte(cmd);
    check("wr_busy_in_frame", busy, 1);
    for (int i = 0; i < n; i++) send_byte(wdat[i]);
    clk_wait(HALF);
    io_ss = 1'b1;
    clk_wait(SS + 1);
    check("wr_busy_release", busy, 0);
    clk_wait(4);
    check("wr_count", wlog.size(), n);
    for (int i = 0; i < n; i++) begin
      a = cmd[6:0] + 7'(i);
      ref_mem[a] = wdat[i];
      if (i < wlog.size()) check("wr_entry", wlog[i], {a, wdat[i]});
    end
  endtask

  task automatic run_read(input logic [6:0] a, input int n);
    logic [1:0] q, oe;
    logic [7:0] b;
    logic       oe_ok;
    logic [6:0] idx;
    wlog.delete();
    io_ss = 1'b0;
    clk_wait(6);
    send_byte({1'b1, a});
    for (int d = 0; d < DUMMY; d++) pair(2'($urandom), q, oe);
    allow_oe = 1'b1;
    for (int i = 0; i < n; i++) begin
      b = '0;
      oe_ok = 1'b1;
      for (int p = 0; p < 4; p++) begin
        pair(2'($urandom), q, oe);
        b = {b[5:0], q};
        if (oe != 2'b11) oe_ok = 1'b0;
      end
      idx = a + 7'(i);
      check("rd_byte", b, ref_mem[idx]);
      check("rd_oe_driven", oe_ok, 1);
    end
    io_ss = 1'b1;
    clk_wait(SS + 1);
    check("rd_busy_release", busy, 0);
    check("rd_oe_release", io_qd_writeEnable, 0);
    allow_oe = 1'b0;
    clk_wait(4);
    check("rd_no_wr", wlog.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time budget exhausted");
    $fatal(1, "watchdog");
  end

  initial begin
    int         n;
    logic [6:0] a;
    for (int i = 0; i < 128; i++) begin
      bus_mem[i] = 8'($urandom);
      ref_mem[i] = bus_mem[i];
    end
    #1 reset = 1'b0;
    clk_wait(3);
    check("rst_oe", io_qd_writeEnable, 0);
    check("rst_qd_write", io_qd_write, 0);
    check("rst_bus_wr", bus_wr, 0);
    check("rst_bus_rd", bus_rd, 0);
    check("rst_busy", busy, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    reset = 1'b1;
    clk_wait(4);
    check("idle_busy", busy, 0);

    // Basic write: cmd 0x05, data A5, 3C.
    wdat[0] = 8'hA5;
    wdat[1] = 8'h3C;
    run_write(8'h05, 2);
`ifdef QSPI_CTRL_DBG_EN
    check("dbg_byte", dbg_byte, 8'h3C);
    check("dbg_frame_cnt", frame_cnt, 1);
    check("dbg_state", dbg_state, 0);
`endif

    // Basic read: host must see 00,01,00,01 then 00,10,00,10.
    bus_mem[5] = 8'h11; ref_mem[5] = 8'h11;
    bus_mem[6] = 8'h22; ref_mem[6] = 8'h22;
    run_read(7'h05, 2);

    // Abort after two data pairs of a write frame.
    wlog.delete();
    io_ss = 1'b0;
    clk_wait(6);
    send_byte(8'h10);
    pair(2'b10, mq, moe);
    pair(2'b11, mq, moe);
    io_ss = 1'b1;
    clk_wait(SS + 1);
    check("abort_busy", busy, 0);
    check("abort_oe", io_qd_writeEnable, 0);
    clk_wait(10);
    check("abort_no_wr", wlog.size(), 0);

    // Address wrap on write.
    wdat[0] = 8'h01;
    wdat[1] = 8'h02;
    run_write(8'h7F, 2);

    // Reset while the slave is driving read data.
    io_ss = 1'b0;
    clk_wait(6);
    send_byte(8'h80 | 8'h30);
    for (int d = 0; d < DUMMY; d++) pair(2'b00, mq, moe);
    allow_oe = 1'b1;
    for (int p = 0; p < 4; p++) pair(2'b00, mq, moe);
    clk_wait(3);
    #1 reset = 1'b0;
    #1;
    check("rstmid_oe", io_qd_writeEnable, 0);
    check("rstmid_bus_rd", bus_rd, 0);
    check("rstmid_busy", busy, 0);
    allow_oe = 1'b0;
    clk_wait(2);
    io_ss = 1'b1;
    io_sclk = 1'b0;
    clk_wait(2);
    reset = 1'b1;
    clk_wait(4);
    run_read(7'h30, 3);

    // Randomised frames against the reference memory.
    for (int k = 0; k < 12; k++) begin
      n = $urandom_range(1, 4);
      a = 7'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        run_read(a, n);
      end else begin
        for (int i = 0; i < n; i++) wdat[i] = 8'($urandom);
        run_write({1'b0, a}, n);
      end
    end

    check("oe_outside_rdata", oe_bad, 0);
    check("wr_rd_same_clk", both_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
